multi_channel_boot_loader: RTL and testbench
============================================

Name: multi_channel_boot_loader

Overview:
- Parametrised boot-time distributor.
- Walks a header-described image in the program-loader ROM and packs WORD_W-bit ROM words into wide beats.
- Writes each beat into one of NUM_CH destination BRAMs (IMEM, HASH, ENC, DEC, …) at an auto-incrementing address.
- After the end marker, asserts cpu_start; replaces the fixed per-memory load sequencing with image-driven, any-width, any-channel loading.

Parameters:
- NUM_CH, 4, number of destination channels (1..15).
- WORD_W, 16, ROM word width (≥ 8 + ADDR_W not required; header1 uses low ADDR_W bits only).
- MAX_WPB, 16, max ROM words per beat (1..16); OUT_W = WORD_W*MAX_WPB.
- ADDR_W, 9, destination address width.
- ROM_AW, 10, ROM address width; ROM depth 2**ROM_AW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reload  in  1  restart load from ROM address 0 (honoured in DONE/ERR only)
- rom_en  out  1  ROM read strobe
- rom_addr  out  ROM_AW  ROM read address
- rom_data  in  WORD_W  ROM data; valid exactly 1 cycle after rom_en
- wr_data  out  OUT_W  packed beat; first word in bits [WORD_W-1:0]; unused upper words zero
- wr_addr  out  ADDR_W  destination address of the beat
- wr_en  out  NUM_CH  one-hot write strobe, 1-cycle pulse
- cpu_start  out  1  level; high in DONE
- busy  out  1  high while loading
- err  out  1  level; high in ERR

Behaviour:
- Image format (16-bit view; WORD_W=16):
  - header0 = {ch[15:12], wpb_m1[11:8], nbeats[7:0]}.
  - header1 = start address; low ADDR_W bits are used.
  - Then nbeats*(wpb_m1+1) data words.
  - ch == 4'hF is the end marker; header1 is not read after it.
- Reset: all outputs 0; rom_addr = 0; state FETCH_H0 (load starts automatically on the first cycle after rst deasserts). busy = 1 in every state except DONE/ERR.
- Each ROM word costs exactly 2 cycles:
  - issue cycle: rom_en = 1, rom_addr = pointer;
  - capture cycle: rom_data registered; pointer += 1.
- States:
  - FETCH_H0:
    - ch == F → DONE.
    - ch ≥ NUM_CH, or wpb_m1+1 > MAX_WPB → ERR.
    - nbeats == 0 → consume header1 then FETCH_H0 (no writes).
    - Otherwise → FETCH_H1.
  - FETCH_H1: latch address → FETCH_DATA.
  - FETCH_DATA:
    - Capture word k into lane k.
    - After lane wpb_m1 → WRITE.
  - WRITE (1 cycle):
    - wr_en[ch] = 1; wr_data = packed beat with lanes > wpb_m1 = 0; wr_addr = current address.
    - Then address += 1 (mod 2**ADDR_W, wraps silently) and beats_left -= 1.
    - beats_left == 0 → FETCH_H0, else clear lanes → FETCH_DATA.
  - DONE: cpu_start = 1, busy = 0, rom_en = 0.
  - ERR: err = 1, busy = 0, cpu_start = 0, no writes.
- wr_data/wr_addr hold their last value outside WRITE; only wr_en qualifies them.
- ROM overflow: a required fetch when pointer would exceed 2**ROM_AW-1 (i.e. after reading the last address without an end marker, the next fetch) → ERR.
- reload = 1 in DONE/ERR: next cycle cpu_start = 0, err = 0, pointer = 0, → FETCH_H0. reload is ignored in all other states.
- rst has priority over reload. rst mid-load aborts immediately: any partially packed beat is discarded and wr_en = 0 on the following cycle.

Test Plan:
- ROM {0x0000 (ch0, wpb 1, 0 beats), 0x0005, 0xF000} → no wr_en. cpu_start rises 6 cycles after rst falls (3 words × 2).
- ROM {0x1101 (ch1, 2 words, 1 beat), 0x0003, 0xAAAA, 0xBBBB, 0xF000} → single wr_en = 4'b0010, wr_addr = 3, wr_data[31:0] = 0xBBBBAAAA, upper bits 0, then cpu_start.
- ch2, wpb 16, 2 beats, addr 0x1FF, 32 data words 0x0000..0x001F → beat at wr_addr 0x1FF with word0 = 0x0000 in lsbs, next beat at wr_addr 0x000 (wrap) with word0 = 0x0010.
- header 0x7000 (ch7 ≥ NUM_CH) → err = 1, busy = 0, no wr_en. Then pulse reload with ROM fixed → err = 0 and the load completes with cpu_start = 1.
- ROM_AW = 3, ROM filled with valid segments but no end marker → err after address 7 is consumed. rst asserted mid-beat in a separate run → wr_en never pulses for that beat; after release the load restarts at rom_addr 0.
- reload pulsed while busy → ignored: the load completes with an identical write sequence.

Source files
------------

// File: rtl/multi_channel_boot_loader.sv
// -----------------------------------------------------------------------------
// multi_channel_boot_loader
//
// Boot-time distributor. It walks a header-described image in the program
// loader ROM, packs WORD_W-bit ROM words into wide beats, and writes each beat
// into one of NUM_CH destination memories at an auto-incrementing address.
// When it reaches the end marker it raises cpu_start.
//
// Image layout (one segment, repeated; bits shown for the 16-bit header view):
//   header0 = {ch[15:12], wpb_m1[11:8], nbeats[7:0]}
//   header1 = start address (low ADDR_W bits used)
//   nbeats * (wpb_m1 + 1) data words
//   ch == 4'hF terminates the image; no header1 follows it.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   reload     restart from ROM address 0; honoured only in DONE / ERR
//   rom_en     ROM read strobe
//   rom_addr   ROM read address
//   rom_data   ROM read data, valid exactly one cycle after rom_en
//   wr_data    packed beat, word 0 in the lsbs, unused upper words zero
//   wr_addr    destination address of the beat
//   wr_en      one-hot per-channel write strobe, one-cycle pulse
//   cpu_start  level, high in DONE
//   busy       high while loading (every state except DONE / ERR)
//   err        level, high in ERR
//
// Strobe semantics: a ROM read is issued in the cycle rom_en is high and its
// data is captured at the end of the following cycle, so every ROM word costs
// two cycles. wr_en is the only qualifier of wr_data / wr_addr; those two
// hold their last written value at all other times. There is no back-pressure
// on either side.
// -----------------------------------------------------------------------------
module multi_channel_boot_loader #(
  parameter int NUM_CH  = 4,
  parameter int WORD_W  = 16,
  parameter int MAX_WPB = 16,
  parameter int ADDR_W  = 9,
  parameter int ROM_AW  = 10,
  localparam int OUT_W  = WORD_W * MAX_WPB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [OUT_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NUM_CH-1:0] wr_en,
  output logic              cpu_start,
  output logic              busy,
  output logic              err
);

  // One extra pointer bit flags that the last ROM address has been consumed.
  localparam int PTR_W = ROM_AW + 1;
  localparam logic [3:0] NUM_CH_L  = 4'(NUM_CH);
  localparam logic [4:0] MAX_WPB_L = 5'(MAX_WPB);

  typedef enum logic [2:0] {
    S_H0    = 3'd0,
    S_H1    = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;     // 0: issue cycle, 1: capture cycle
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         ch_q, ch_d;
  logic [3:0]         wpb_m1_q, wpb_m1_d;
  logic [7:0]         beats_q, beats_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         lane_q, lane_d;
  logic [OUT_W-1:0]   pack_q, pack_d;
  logic [OUT_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               rom_issue;
  logic [OUT_W-1:0]   beat_next;

  // Header0 field view of the captured ROM word.
  logic [3:0] hdr_ch;
  logic [3:0] hdr_wpb_m1;
  logic [7:0] hdr_nbeats;
  logic       hdr_bad;

  assign hdr_ch     = rom_data[15:12];
  assign hdr_wpb_m1 = rom_data[11:8];
  assign hdr_nbeats = rom_data[7:0];
  assign hdr_bad    = (hdr_ch >= NUM_CH_L) ||
                      (({1'b0, hdr_wpb_m1} + 5'd1) > MAX_WPB_L);

  // Current partial beat with the incoming word dropped into lane lane_q.
  always_comb begin
    beat_next = pack_q;
    for (int i = 0; i < MAX_WPB; i++) begin
      if (lane_q == 4'(i)) begin
        beat_next[i*WORD_W +: WORD_W] = rom_data;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    wpb_m1_d  = wpb_m1_q;
    beats_d   = beats_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    rom_issue = 1'b0;

    unique case (state_q)
      S_H0, S_H1, S_DATA: begin
        if (!phase_q) begin
          // A fetch is needed; running past the top of the ROM is fatal.
          if (ptr_q[ROM_AW]) begin
            state_d = S_ERR;
          end else begin
            rom_issue = 1'b1;
            phase_d   = 1'b1;
          end
        end else begin
          phase_d = 1'b0;
          ptr_d   = ptr_q + PTR_W'(1);
          if (state_q == S_H0) begin
            if (hdr_ch == 4'hF) begin
              state_d = S_DONE;
            end else if (hdr_bad) begin
              state_d = S_ERR;
            end else begin
              ch_d     = hdr_ch;
              wpb_m1_d = hdr_wpb_m1;
              beats_d  = hdr_nbeats;
              state_d  = S_H1;
            end
          end else if (state_q == S_H1) begin
            addr_d = rom_data[ADDR_W-1:0];
            // An empty segment still carries its header1 word.
            if (beats_q == 8'd0) begin
              state_d = S_H0;
            end else begin
              lane_d  = 4'd0;
              pack_d  = '0;
              state_d = S_DATA;
            end
          end else begin
            pack_d = beat_next;
            if (lane_q == wpb_m1_q) begin
              wr_data_d = beat_next;
              wr_addr_d = addr_q;
              state_d   = S_WRITE;
            end else begin
              lane_d = lane_q + 4'd1;
            end
          end
        end
      end

      S_WRITE: begin
        // Destination address wraps silently at 2**ADDR_W.
        addr_d  = addr_q + ADDR_W'(1);
        beats_d = beats_q - 8'd1;
        lane_d  = 4'd0;
        pack_d  = '0;
        phase_d = 1'b0;
        state_d = (beats_q == 8'd1) ? S_H0 : S_DATA;
      end

      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_H0;
          phase_d = 1'b0;
          ptr_d   = '0;
        end
      end

      default: begin
        state_d = S_H0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_H0;
      phase_q   <= 1'b0;
      ptr_q     <= '0;
      ch_q      <= '0;
      wpb_m1_q  <= '0;
      beats_q   <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ptr_q     <= ptr_d;
      ch_q      <= ch_d;
      wpb_m1_q  <= wpb_m1_d;
      beats_q   <= beats_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Control outputs are forced low while rst is held so every output reads
  // zero during reset, and the first fetch appears as soon as rst drops.
  always_comb begin
    rom_en    = !rst && rom_issue;
    rom_addr  = rst ? '0 : ptr_q[ROM_AW-1:0];
    busy      = !rst && (state_q != S_DONE) && (state_q != S_ERR);
    cpu_start = !rst && (state_q == S_DONE);
    err       = !rst && (state_q == S_ERR);
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = !rst && (state_q == S_WRITE) && (ch_q == 4'(i));
    end
  end

  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_multi_channel_boot_loader.sv
// -----------------------------------------------------------------------------
// Directed bench for multi_channel_boot_loader. Two instances: the default
// configuration, and a ROM_AW = 3 copy for the ROM-overflow case. Each
// instance has a synchronous ROM model and a write monitor that logs every
// wr_en pulse.
// -----------------------------------------------------------------------------
module tb_multi_channel_boot_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         reload = 1'b0;
  logic         rom_en;
  logic [9:0]   rom_addr;
  logic [15:0]  rom_data = '0;
  logic [255:0] wr_data;
  logic [8:0]   wr_addr;
  logic [3:0]   wr_en;
  logic         cpu_start, busy, err;

  logic         rst_s = 1'b1;
  logic         reload_s = 1'b0;
  logic         rom_en_s;
  logic [2:0]   rom_addr_s;
  logic [15:0]  rom_data_s = '0;
  logic [255:0] wr_data_s;
  logic [8:0]   wr_addr_s;
  logic [3:0]   wr_en_s;
  logic         cpu_start_s, busy_s, err_s;

  multi_channel_boot_loader dut (
    .clk(clk), .rst(rst), .reload(reload),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .cpu_start(cpu_start), .busy(busy), .err(err)
  );

  multi_channel_boot_loader #(.ROM_AW(3)) dut_s (
    .clk(clk), .rst(rst_s), .reload(reload_s),
    .rom_en(rom_en_s), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .wr_data(wr_data_s), .wr_addr(wr_addr_s), .wr_en(wr_en_s),
    .cpu_start(cpu_start_s), .busy(busy_s), .err(err_s)
  );

  // ---------------- ROM models ----------------
  logic [15:0] rom   [0:1023];
  logic [15:0] rom_s [0:7];

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];
  always @(posedge clk) if (rom_en_s) rom_data_s <= rom_s[rom_addr_s];

  // ---------------- write monitors ----------------
  logic [3:0]   en_q[$];
  logic [8:0]   addr_q[$];
  logic [255:0] data_q[$];
  logic [3:0]   en_s_q[$];
  logic [8:0]   addr_s_q[$];
  logic [255:0] data_s_q[$];

  always @(negedge clk) begin
    if (wr_en != 4'd0) begin
      en_q.push_back(wr_en);
      addr_q.push_back(wr_addr);
      data_q.push_back(wr_data);
    end
    if (wr_en_s != 4'd0) begin
      en_s_q.push_back(wr_en_s);
      addr_s_q.push_back(wr_addr_s);
      data_s_q.push_back(wr_data_s);
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [3:0] e_en,
                             input logic [8:0] e_addr, input logic [255:0] e_data);
    logic [3:0]   g_en;
    logic [8:0]   g_addr;
    logic [255:0] g_data;
    g_en   = (idx < en_q.size()) ? en_q[idx]   : 'x;
    g_addr = (idx < en_q.size()) ? addr_q[idx] : 'x;
    g_data = (idx < en_q.size()) ? data_q[idx] : 'x;
    check({tag, "_en"},   256'(g_en),   256'(e_en));
    check({tag, "_addr"}, 256'(g_addr), 256'(e_addr));
    check({tag, "_data"}, g_data,       e_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 16'hF000;
  endtask

  task automatic clear_log();
    en_q.delete(); addr_q.delete(); data_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    reload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  // Counts rising edges until cpu_start or err; reload is held high for the
  // first 'hold' sampled edges.
  task automatic wait_main(input int max, input int hold, output int cycles);
    cycles = 0;
    reload = (hold > 0);
    do begin
      @(posedge clk);
      #1;
      cycles++;
      reload = (cycles < hold);
    end while (!(cpu_start || err) && cycles < max);
    reload = 1'b0;
  endtask

  task automatic load_two_word_image();
    fill_rom();
    rom[0] = 16'h1101;
    rom[1] = 16'h0003;
    rom[2] = 16'hAAAA;
    rom[3] = 16'hBBBB;
    rom[4] = 16'hF000;
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  logic [255:0] exp0, exp1;

  initial begin
    // --- reset state ---
    fill_rom();
    rom[0] = 16'h0000;
    rom[1] = 16'h0005;
    rom[2] = 16'hF000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_en",    256'(rom_en),    256'd0);
    check("rst_rom_addr",  256'(rom_addr),  256'd0);
    check("rst_busy",      256'(busy),      256'd0);
    check("rst_cpu_start", 256'(cpu_start), 256'd0);
    check("rst_err",       256'(err),       256'd0);
    check("rst_wr_en",     256'(wr_en),     256'd0);
    check("rst_wr_data",   wr_data,         256'd0);
    check("rst_wr_addr",   256'(wr_addr),   256'd0);

    // --- empty segment then end marker ---
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    #1;
    check("t1_first_rom_en",   256'(rom_en),   256'd1);
    check("t1_first_rom_addr", 256'(rom_addr), 256'd0);
    check("t1_first_busy",     256'(busy),     256'd1);
    wait_main(200, 0, cyc);
    check("t1_cycles",    256'(cyc),             256'd6);
    check("t1_cpu_start", 256'(cpu_start),       256'd1);
    check("t1_busy",      256'(busy),            256'd0);
    check("t1_err",       256'(err),             256'd0);
    check("t1_rom_en",    256'(rom_en),          256'd0);
    check("t1_writes",    256'(en_q.size()),     256'd0);

    // --- one beat of two words on ch1 ---
    load_two_word_image();
    apply_reset();
    wait_main(200, 0, cyc);
    check("t2_cycles",    256'(cyc),         256'd11);
    check("t2_cpu_start", 256'(cpu_start),   256'd1);
    check("t2_writes",    256'(en_q.size()), 256'd1);
    check_write("t2_w0", 0, 4'b0010, 9'd3, 256'hBBBB_AAAA);
    @(posedge clk);
    #1;
    check("t2_hold_data", wr_data,         256'hBBBB_AAAA);
    check("t2_hold_addr", 256'(wr_addr),   256'd3);
    check("t2_hold_en",   256'(wr_en),     256'd0);

    // --- full-width beats, destination address wrap ---
    fill_rom();
    rom[0] = 16'h2F02;
    rom[1] = 16'h01FF;
    for (int k = 0; k < 32; k++) rom[2+k] = 16'(k);
    rom[34] = 16'hF000;
    exp0 = '0;
    exp1 = '0;
    for (int k = 0; k < 16; k++) begin
      exp0[k*16 +: 16] = 16'(k);
      exp1[k*16 +: 16] = 16'(k + 16);
    end
    apply_reset();
    wait_main(500, 0, cyc);
    check("t3_cycles",    256'(cyc),         256'd72);
    check("t3_cpu_start", 256'(cpu_start),   256'd1);
    check("t3_writes",    256'(en_q.size()), 256'd2);
    check_write("t3_w0", 0, 4'b0100, 9'h1FF, exp0);
    check_write("t3_w1", 1, 4'b0100, 9'h000, exp1);

    // --- illegal channel, then reload with a good image ---
    fill_rom();
    rom[0] = 16'h7000;
    apply_reset();
    wait_main(200, 0, cyc);
    check("t4_cycles",    256'(cyc),         256'd2);
    check("t4_err",       256'(err),         256'd1);
    check("t4_busy",      256'(busy),        256'd0);
    check("t4_cpu_start", 256'(cpu_start),   256'd0);
    check("t4_writes",    256'(en_q.size()), 256'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_err_stays", 256'(err),         256'd1);
    load_two_word_image();
    clear_log();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("t4_reload_err",      256'(err),      256'd0);
    check("t4_reload_busy",     256'(busy),     256'd1);
    check("t4_reload_rom_en",   256'(rom_en),   256'd1);
    check("t4_reload_rom_addr", 256'(rom_addr), 256'd0);
    wait_main(200, 0, cyc);
    check("t4_cycles2",   256'(cyc),         256'd11);
    check("t4_cpu_start2", 256'(cpu_start),  256'd1);
    check("t4_err2",      256'(err),         256'd0);
    check("t4_writes2",   256'(en_q.size()), 256'd1);
    check_write("t4_w0", 0, 4'b0010, 9'd3, 256'hBBBB_AAAA);

    // --- ROM overflow on the ROM_AW = 3 instance ---
    rom_s[0] = 16'h0001;
    rom_s[1] = 16'h0000;
    rom_s[2] = 16'h1111;
    rom_s[3] = 16'h1001;
    rom_s[4] = 16'h0002;
    rom_s[5] = 16'h2222;
    rom_s[6] = 16'h0000;
    rom_s[7] = 16'h0007;
    @(negedge clk);
    rst_s = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(cpu_start_s || err_s) && cyc < 200);
    check("t5_cycles",    256'(cyc),           256'd19);
    check("t5_err",       256'(err_s),         256'd1);
    check("t5_cpu_start", 256'(cpu_start_s),   256'd0);
    check("t5_busy",      256'(busy_s),        256'd0);
    check("t5_writes",    256'(en_s_q.size()), 256'd2);
    check("t5_w0_en",   256'((en_s_q.size() > 0) ? en_s_q[0]   : 4'hx),  256'(4'b0001));
    check("t5_w0_addr", 256'((en_s_q.size() > 0) ? addr_s_q[0] : 9'hx),  256'd0);
    check("t5_w0_data", (data_s_q.size() > 0) ? data_s_q[0] : 'x,        256'h1111);
    check("t5_w1_en",   256'((en_s_q.size() > 1) ? en_s_q[1]   : 4'hx),  256'(4'b0010));
    check("t5_w1_addr", 256'((en_s_q.size() > 1) ? addr_s_q[1] : 9'hx),  256'd2);
    check("t5_w1_data", (data_s_q.size() > 1) ? data_s_q[1] : 'x,        256'h2222);

    // --- rst in the middle of a beat ---
    load_two_word_image();
    apply_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_rst_wr_en",  256'(wr_en),       256'd0);
    check("t6_rst_rom_en", 256'(rom_en),      256'd0);
    check("t6_rst_writes", 256'(en_q.size()), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_restart_rom_en",   256'(rom_en),   256'd1);
    check("t6_restart_rom_addr", 256'(rom_addr), 256'd0);
    wait_main(200, 0, cyc);
    check("t6_cycles",    256'(cyc),         256'd11);
    check("t6_cpu_start", 256'(cpu_start),   256'd1);
    check("t6_writes",    256'(en_q.size()), 256'd1);
    check_write("t6_w0", 0, 4'b0010, 9'd3, 256'hBBBB_AAAA);

    // --- reload while busy is ignored ---
    fill_rom();
    rom[0] = 16'h1101;
    rom[1] = 16'h0003;
    rom[2] = 16'hAAAA;
    rom[3] = 16'hBBBB;
    rom[4] = 16'h0002;
    rom[5] = 16'h0010;
    rom[6] = 16'h1234;
    rom[7] = 16'h5678;
    rom[8] = 16'hF000;
    apply_reset();
    wait_main(200, 15, cyc);
    check("t7_cycles",    256'(cyc),         256'd21);
    check("t7_cpu_start", 256'(cpu_start),   256'd1);
    check("t7_writes",    256'(en_q.size()), 256'd3);
    check_write("t7_w0", 0, 4'b0010, 9'h003, 256'hBBBB_AAAA);
    check_write("t7_w1", 1, 4'b0001, 9'h010, 256'h1234);
    check_write("t7_w2", 2, 4'b0001, 9'h011, 256'h5678);
    repeat (2) @(posedge clk);
    #1;
    check("t7_done_stays", 256'(cpu_start),   256'd1);
    check("t7_no_rewrite", 256'(en_q.size()), 256'd3);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
